sdram_arbiter: RTL

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arb_pkg.sv | 25 ++
 rtl/sdram_arb_tag_fifo.sv | 56 +++++
 rtl/sdram_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-requester SDRAM arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package sdram_arb_pkg;

  localparam int AVL_DATA_W = 64;
  localparam int AVL_BE_W   = 8;
  localparam int BURST_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ_CMD,
    WRITE_BURST
  } arb_state_t;

  // Requester identifier: 0 = m0, 1 = m1.
  typedef logic req_id_t;

  // One outstanding read: who asked for it and how many beats come back.
  typedef struct packed {
    req_id_t            id;
    logic [BURST_W-1:0] len;
  } tag_t;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order record of outstanding read commands ({requester id, burst length}).
// Latency: a pushed entry reaches the head on the next cycle; the head is read combinationally.
// Backpressure: full/empty flags only; pushes while full and pops while empty are ignored.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output tag_t head_tag,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  tag_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign head_tag = mem[rd_ptr];

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  // Wrap-around pointers and occupancy; a push and a pop together leave count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester Avalon-MM burst arbiter onto one SDRAM port; reads are tagged so returns route back in order.
// Latency: one IDLE cycle to grant, then commands pass combinationally; read data returns with zero added latency.
// Backpressure: s_waitrequest reaches the granted requester only; others stall, reads stall while the tag FIFO is full.
// Build option: define SDRAM_ARB_FIXED_PRIORITY_EN to make requester 0 win every conflict instead of round-robin.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = 29,
  parameter int TAG_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [BURST_W-1:0]    m0_burstcount,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [AVL_DATA_W-1:0] m0_writedata,
  input  logic [AVL_BE_W-1:0]   m0_byteenable,
  output logic                  m0_waitrequest,
  output logic [AVL_DATA_W-1:0] m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [BURST_W-1:0]    m1_burstcount,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [AVL_DATA_W-1:0] m1_writedata,
  input  logic [AVL_BE_W-1:0]   m1_byteenable,
  output logic                  m1_waitrequest,
  output logic [AVL_DATA_W-1:0] m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     s_address,
  output logic [BURST_W-1:0]    s_burstcount,
  output logic                  s_read,
  output logic                  s_write,
  output logic [AVL_DATA_W-1:0] s_writedata,
  output logic [AVL_BE_W-1:0]   s_byteenable,
  input  logic                  s_waitrequest,
  input  logic [AVL_DATA_W-1:0] s_readdata,
  input  logic                  s_readdatavalid
);

  arb_state_t         state, state_nxt;
  req_id_t            grant, grant_nxt;   // current grant, doubles as last-granted
  logic [BURST_W-1:0] burst_len, burst_len_nxt;
  logic [BURST_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [BURST_W-1:0] ret_cnt;
  logic               proto_err;

  logic               g_read, g_write;
  logic               elig0, elig1;
  req_id_t            winner;
  logic               win_write;
  logic [BURST_W-1:0] win_burst;

  tag_t               push_tag, head_tag;
  logic               tag_push, tag_pop, tag_full, tag_empty;
  logic               ret_ok, ret_last;

  // A read can only be granted when there is room to remember where its data goes.
  assign elig0 = m0_write | (m0_read & ~tag_full);
  assign elig1 = m1_write | (m1_read & ~tag_full);

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
  // Display scanout (m0) always wins.
  assign winner = elig0 ? 1'b0 : 1'b1;
`else
  // On a conflict the requester not granted last time wins.
  assign winner = (elig0 & elig1) ? ~grant : (elig0 ? 1'b0 : 1'b1);
`endif

  assign win_write = winner ? m1_write      : m0_write;
  assign win_burst = winner ? m1_burstcount : m0_burstcount;

  // Command payload follows the current grant; strobes are qualified by the FSM below.
  always_comb begin
    if (grant) begin
      s_address    = m1_address;
      s_burstcount = m1_burstcount;
      s_writedata  = m1_writedata;
      s_byteenable = m1_byteenable;
      g_read       = m1_read;
      g_write      = m1_write;
    end else begin
      s_address    = m0_address;
      s_burstcount = m0_burstcount;
      s_writedata  = m0_writedata;
      s_byteenable = m0_byteenable;
      g_read       = m0_read;
      g_write      = m0_write;
    end
  end

  // Next-state, grant, beat counting, strobes and stall outputs.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    burst_len_nxt  = burst_len;
    beat_cnt_nxt   = beat_cnt;
    s_read         = 1'b0;
    s_write        = 1'b0;
    tag_push       = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          grant_nxt     = winner;
          burst_len_nxt = win_burst;
          beat_cnt_nxt  = '0;
          state_nxt     = win_write ? WRITE_BURST : READ_CMD;
        end
      end
      READ_CMD: begin
        s_read = g_read;
        if (grant) m1_waitrequest = s_waitrequest;
        else       m0_waitrequest = s_waitrequest;
        if (g_read && !s_waitrequest) begin
          tag_push  = 1'b1;
          state_nxt = IDLE;
        end
      end
      WRITE_BURST: begin
        s_write = g_write;
        if (grant) m1_waitrequest = s_waitrequest;
        else       m0_waitrequest = s_waitrequest;
        if (g_write && !s_waitrequest) begin
          if (beat_cnt == burst_len - 8'd1) begin
            beat_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Hold the SDRAM side quiet and everyone stalled for the whole reset window.
    if (reset) begin
      s_read         = 1'b0;
      s_write        = 1'b0;
      tag_push       = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
    end
  end

  // FSM state, grant and write-burst bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 1'b1;   // so requester 0 wins the first conflict
      burst_len <= '0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      burst_len <= burst_len_nxt;
      beat_cnt  <= beat_cnt_nxt;
    end
  end

  assign push_tag = '{id: grant, len: s_burstcount};

  sdram_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (tag_push),
    .push_tag (push_tag),
    .pop      (tag_pop),
    .head_tag (head_tag),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  // Returns go to whoever owns the head tag; beats with no owner are dropped.
  assign ret_ok           = s_readdatavalid & ~tag_empty & ~reset;
  assign ret_last         = (ret_cnt == head_tag.len - 8'd1);
  assign tag_pop          = ret_ok & ret_last;
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = ret_ok & (head_tag.id == 1'b0);
  assign m1_readdatavalid = ret_ok & (head_tag.id == 1'b1);

  // Return-beat counter and sticky flag for data arriving with nothing outstanding.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ret_cnt   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (ret_ok) ret_cnt <= ret_last ? '0 : ret_cnt + 8'd1;
      if (s_readdatavalid && tag_empty) proto_err <= 1'b1;
    end
  end

endmodule
